// File: rtl/hello_world_core.sv
// Filtered two-input gate: synchronize, debounce, combine, register.
// Also reports output transitions as a pulse and a saturating count.
module hello_world_core #(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int OP          = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    output logic             c,
    output logic             a_flt,
    output logic             b_flt,
    output logic             c_chg,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic [1:0]             s;
    logic [1:0]             flt;
    logic [DB_W-1:0]        db_cnt [2];
    logic                   c_nx;

    assign s     = {b_sync[SYNC_STAGES-1], a_sync[SYNC_STAGES-1]};
    assign a_flt = flt[0];
    assign b_flt = flt[1];

    // Synchronizer chains, one per asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b};
        end
    end

    // Debounce: accept a new level only after DEBOUNCE mismatching cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            flt       <= '0;
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s[i] == flt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    flt[i]    <= s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Gate function selected at elaboration; unused codes fall back to AND.
    always_comb begin
        c_nx = flt[0] & flt[1];
        case (OP)
            1:       c_nx = flt[0] | flt[1];
            2:       c_nx = flt[0] ^ flt[1];
            3:       c_nx = ~(flt[0] & flt[1]);
            4:       c_nx = ~(flt[0] | flt[1]);
            5:       c_nx = ~(flt[0] ^ flt[1]);
            default: c_nx = flt[0] & flt[1];
        endcase
    end

    // Registered result, change pulse and saturating transition count.
    always_ff @(posedge clk) begin
        if (rst) begin
            c          <= 1'b0;
            c_chg      <= 1'b0;
            toggle_cnt <= '0;
        end else begin
            c     <= c_nx;
            c_chg <= c_nx ^ c;
            if ((c_nx != c) && (toggle_cnt != {CNT_W{1'b1}})) begin
                toggle_cnt <= toggle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hello_world_core.sv
// Bench for hello_world_core: four instances (AND, XOR, NAND, AND/2-bit
// count) share stimulus and are checked against a queue-based model.
module tb_hello_world_core;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int OPS [N] = '{0, 2, 3, 0};
    localparam int CWS [N] = '{8, 8, 8, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a   = 1'b0;
    logic b   = 1'b0;

    logic [N-1:0] c_d;
    logic [N-1:0] af_d;
    logic [N-1:0] bf_d;
    logic [N-1:0] chg_d;
    logic [7:0]   tc_d [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int CW = CWS[g];
        logic [CW-1:0] tc;
        hello_world_core #(
            .SYNC_STAGES(SS),
            .DEBOUNCE   (DB),
            .OP         (OPS[g]),
            .CNT_W      (CW)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .a         (a),
            .b         (b),
            .c         (c_d[g]),
            .a_flt     (af_d[g]),
            .b_flt     (bf_d[g]),
            .c_chg     (chg_d[g]),
            .toggle_cnt(tc)
        );
        assign tc_d[g] = 8'(tc);
    end

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit ah [$];
    bit bh [$];
    bit aw [$];
    bit bw [$];
    bit m_af, m_bf, mvalid;
    bit m_c   [N];
    bit m_chg [N];
    int m_tc  [N];

    function automatic bit gate(int op, bit x, bit y);
        case (op)
            1:       return x | y;
            2:       return x ^ y;
            3:       return !(x & y);
            4:       return !(x | y);
            5:       return !(x ^ y);
            default: return x & y;
        endcase
    endfunction

    function automatic bit all_differ(bit q [$], bit v);
        foreach (q[i]) if (q[i] == v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic mreset();
        ah = {}; bh = {}; aw = {}; bw = {};
        repeat (SS) begin ah.push_back(1'b0); bh.push_back(1'b0); end
        repeat (DB) begin aw.push_back(1'b0); bw.push_back(1'b0); end
        m_af = 0; m_bf = 0;
        for (int i = 0; i < N; i++) begin
            m_c[i] = 0; m_chg[i] = 0; m_tc[i] = 0;
        end
    endtask

    // Model: input seen SS edges late; level accepted after DB differing samples.
    always @(posedge clk) begin
        if (rst) begin
            mreset();
            mvalid = 1'b1;
        end else if (mvalid) begin
            bit sa, sb, na, nb, cn;
            sa = ah[SS-1];
            sb = bh[SS-1];
            ah.push_front(a); void'(ah.pop_back());
            bh.push_front(b); void'(bh.pop_back());
            aw.push_front(sa); void'(aw.pop_back());
            bw.push_front(sb); void'(bw.pop_back());
            na = all_differ(aw, m_af) ? sa : m_af;
            nb = all_differ(bw, m_bf) ? sb : m_bf;
            for (int i = 0; i < N; i++) begin
                cn = gate(OPS[i], m_af, m_bf);
                m_chg[i] = (cn != m_c[i]);
                if (m_chg[i] && m_tc[i] < (1 << CWS[i]) - 1) m_tc[i]++;
                m_c[i] = cn;
            end
            m_af = na;
            m_bf = nb;
        end
    end

    // Compare every instance against the model each cycle.
    always @(negedge clk) begin
        if (mvalid) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("c[%0d]", i),   c_d[i],   m_c[i]);
                chk($sformatf("af[%0d]", i),  af_d[i],  m_af);
                chk($sformatf("bf[%0d]", i),  bf_d[i],  m_bf);
                chk($sformatf("chg[%0d]", i), chg_d[i], m_chg[i]);
                chk($sformatf("tc[%0d]", i),  tc_d[i],  m_tc[i]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_c_nand", c_d[2], 0);
        chk("rst_tc", tc_d[0], 0);
        chk("rst_af", af_d[0], 0);

        // NAND takes 1 on the first edge after release
        rst = 1'b0;
        @(negedge clk);
        chk("nand_c", c_d[2], 1);
        chk("nand_chg", chg_d[2], 1);
        chk("nand_tc", tc_d[2], 1);
        @(negedge clk);
        chk("nand_chg_drop", chg_d[2], 0);

        // idle 100 cycles
        n = 0;
        repeat (100) begin @(negedge clk); n += int'(chg_d[0]); end
        chk("idle_chg", n, 0);
        chk("idle_tc", tc_d[0], 0);

        // a=b=1: filter at N+5, c at N+6
        a = 1'b1; b = 1'b1;
        repeat (5) @(negedge clk);
        chk("lat_af_early", af_d[0], 0);
        @(negedge clk);
        chk("lat_af", af_d[0], 1);
        chk("lat_bf", bf_d[0], 1);
        chk("lat_c_early", c_d[0], 0);
        @(negedge clk);
        chk("lat_c", c_d[0], 1);
        chk("lat_chg", chg_d[0], 1);
        chk("lat_tc", tc_d[0], 1);
        @(negedge clk);
        chk("lat_chg_drop", chg_d[0], 0);
        chk("xor_simul_tc", tc_d[1], 0);

        a = 1'b0; b = 1'b0;
        repeat (10) @(negedge clk);
        chk("and_back_tc", tc_d[0], 2);

        // 3-cycle glitch is swallowed
        a = 1'b1;
        repeat (3) @(negedge clk);
        a = 1'b0;
        n = 0;
        repeat (14) begin @(negedge clk); n += int'(af_d[1]); end
        chk("glitch_af_hi", n, 0);
        chk("glitch_tc", tc_d[1], 0);

        // 4-cycle pulse passes as a 4-cycle filtered pulse
        a = 1'b1;
        repeat (4) @(negedge clk);
        a = 1'b0;
        n = 0;
        repeat (14) begin @(negedge clk); n += int'(af_d[1]); end
        chk("pulse_af_hi", n, 4);
        chk("pulse_tc", tc_d[1], 2);

        // saturation with b=1, five stable toggles of a
        b = 1'b1;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            a = ~a;
            repeat (8) @(negedge clk);
        end
        chk("sat_tc2", tc_d[3], 3);
        chk("sat_tc8", tc_d[0], 7);
        chk("sat_c", c_d[0], 1);

        // reset mid-debounce with c=1
        a = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("mid_rst_c[%0d]", i), c_d[i], 0);
            chk($sformatf("mid_rst_af[%0d]", i), af_d[i], 0);
            chk($sformatf("mid_rst_bf[%0d]", i), bf_d[i], 0);
            chk($sformatf("mid_rst_chg[%0d]", i), chg_d[i], 0);
            chk($sformatf("mid_rst_tc[%0d]", i), tc_d[i], 0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("relat_af_early", af_d[0], 0);
        @(negedge clk);
        chk("relat_af", af_d[0], 1);
        @(negedge clk);
        chk("relat_c", c_d[0], 1);
        chk("relat_tc", tc_d[0], 1);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hello_world_core.md
Name: hello_world_core

Overview:
- Two-input filtered logic gate: 1-bit inputs a and b are synchronized, glitch-filtered and combined by a parameter-selected Boolean function into registered output c.
- Also reports output transitions: a change pulse and a saturating transition counter.
- Bring-up / sanity block. Sits between asynchronous board-level signals (switches, straps) and synchronous control logic.

Parameters:
- SYNC_STAGES, 2, synchronizer flops per input; legal range 2..4.
- DEBOUNCE, 4, consecutive cycles a synchronized input must differ from its filtered value before the filtered value updates; legal range 1..255.
- OP, 0, gate function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6..7 treated as AND.
- CNT_W, 8, width of the transition counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  1  asynchronous operand A.
- b  input  1  asynchronous operand B.
- c  output  1  registered result OP(a_flt, b_flt).
- a_flt  output  1  debounced, synchronized A.
- b_flt  output  1  debounced, synchronized B.
- c_chg  output  1  one-cycle pulse when c changes value.
- toggle_cnt  output  CNT_W  count of c transitions since reset, saturating.

Behaviour:
- Reset:
  - rst is sampled on a rising clk edge.
  - That edge clears all synchronizer flops, debounce counters, a_flt, b_flt, c, c_chg and toggle_cnt to 0.
  - Reset has priority over all other activity, including mid-debounce and mid-count.
  - c resets to 0 regardless of OP, even where OP(0,0)=1 (NAND/NOR/XNOR). c then takes its computed value on the first post-reset edge, and that edge counts as a transition.
- Synchronizer:
  - Each input passes through a chain of SYNC_STAGES flops.
  - a_s / b_s denote the last stage of each chain.
- Debounce, per input, independent:
  - A counter counts each cycle in which the synchronized value differs from the filtered value.
  - Any cycle in which they match clears the counter to 0.
  - When the counter has seen DEBOUNCE consecutive mismatching cycles, the filtered value takes the synchronized value on that edge, and the counter clears.
  - Pulses shorter than DEBOUNCE cycles after synchronization never reach the filtered output.
- Gate: c <= OP(a_flt, b_flt) every edge (registered, one cycle after the filter).
- Latency:
  - Let N be the first edge that samples a new, stable input value.
  - The filtered value changes at edge N+SYNC_STAGES+DEBOUNCE-1.
  - c changes at edge N+SYNC_STAGES+DEBOUNCE. With defaults that is N+6.
- c_chg:
  - High for exactly the cycle in which c holds a new value (registered compare of next vs current c).
  - Low otherwise, and low during and immediately after reset except for the post-reset transition case above.
- toggle_cnt:
  - Increments by 1 on every c transition.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Simultaneous events:
  - a and b changing together are filtered independently and may reach c on the same edge.
  - If both filtered inputs change on the same edge and OP's result is unchanged (e.g. XOR 01->10), there is no c_chg and no count.
- No combinational path from any input to any output.

Test Plan:
- Reset, then a=0, b=0 held 100 cycles, OP=0 -> c=0, c_chg never asserted, toggle_cnt=0.
- OP=0: a=1, b=1 applied at edge N -> a_flt=b_flt=1 at N+5, c=1 and c_chg=1 at N+6, toggle_cnt=1; c_chg=0 at N+7.
- OP=2, DEBOUNCE=4: 3-cycle glitch a=1 then back to 0 -> a_flt stays 0, c stays 0, toggle_cnt=0; a 4-cycle pulse -> a_flt=1 for 4 cycles, c toggles 0->1->0, toggle_cnt=2.
- OP=3 (NAND): first edge after reset release with a=b=0 -> c=1, c_chg=1, toggle_cnt=1.
- CNT_W=2, OP=0: toggle a stably 5 times with b=1 -> toggle_cnt saturates at 3.
- Assert rst while a mid-debounce (counter=2) and c=1 -> next edge all outputs 0; after release a held 1 needs the full SYNC_STAGES+DEBOUNCE edges again.
